vga_cursor_overlay: RTL



---
 rtl/vga_cursor_overlay.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vga_cursor_overlay.sv
`default_nettype none
// ============================================================================
// Module   : vga_cursor_overlay
// Brief    : Recovers pixel x/y from the blank/sync strobes and composites a
//            rectangular cursor one pixel-clock after the VGA controller.
//            Build option: CURSOR_BLEND_EN selects a 50% blend instead of
//            an opaque cursor.
// Revision : 1.0 - initial release
// ============================================================================
module vga_cursor_overlay #(
    parameter int CUR_W = 16,
    parameter int CUR_H = 16,
    parameter int XW    = 10
) (
    input  logic          iRST_n,
    input  logic          iVGA_CLK,
    input  logic          iBLANK_n,
    input  logic          iHS,
    input  logic          iVS,
    input  logic [7:0]    iR,
    input  logic [7:0]    iG,
    input  logic [7:0]    iB,
    input  logic          iCUR_EN,
    input  logic [XW-1:0] iCUR_X,
    input  logic [XW-1:0] iCUR_Y,
    input  logic [23:0]   iCUR_COLOR,
    output logic          oBLANK_n,
    output logic          oHS,
    output logic          oVS,
    output logic [7:0]    oR,
    output logic [7:0]    oG,
    output logic [7:0]    oB,
    output logic          oFRAME
);

    localparam logic [XW:0]   C_CUR_W = (XW+1)'(CUR_W);
    localparam logic [XW:0]   C_CUR_H = (XW+1)'(CUR_H);
    localparam logic [XW-1:0] C_CMAX  = {XW{1'b1}};

    logic [XW-1:0] r_x_cnt;
    logic [XW-1:0] r_y_cnt;
    logic          r_prev_blank;
    logic          r_prev_vs;
    logic          r_en_s;
    logic [XW-1:0] r_x_s;
    logic [XW-1:0] r_y_s;

    logic          w_vs_fall;
    logic          w_blank_fall;
    logic [XW:0]   w_x_end;
    logic [XW:0]   w_y_end;
    logic          w_hit;
    logic [7:0]    w_cur_r;
    logic [7:0]    w_cur_g;
    logic [7:0]    w_cur_b;

    assign w_vs_fall    = r_prev_vs & ~iVS;
    assign w_blank_fall = r_prev_blank & ~iBLANK_n;

    // One extra bit on the far edges so a cursor near the right/bottom clips
    assign w_x_end = {1'b0, r_x_s} + C_CUR_W;
    assign w_y_end = {1'b0, r_y_s} + C_CUR_H;

    assign w_hit = r_en_s & iBLANK_n
                 & (r_x_cnt >= r_x_s) & ({1'b0, r_x_cnt} < w_x_end)
                 & (r_y_cnt >= r_y_s) & ({1'b0, r_y_cnt} < w_y_end);

`ifdef CURSOR_BLEND_EN
    // Halving both operands first keeps the sum within 8 bits (max 254)
    assign w_cur_r = {1'b0, iR[7:1]} + {1'b0, iCUR_COLOR[7:1]};
    assign w_cur_g = {1'b0, iG[7:1]} + {1'b0, iCUR_COLOR[15:9]};
    assign w_cur_b = {1'b0, iB[7:1]} + {1'b0, iCUR_COLOR[23:17]};
`else
    assign w_cur_r = iCUR_COLOR[7:0];
    assign w_cur_g = iCUR_COLOR[15:8];
    assign w_cur_b = iCUR_COLOR[23:16];
`endif

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_prev_blank <= 1'b0;
            r_prev_vs    <= 1'b1;
            r_en_s       <= 1'b0;
            r_x_s        <= '0;
            r_y_s        <= '0;
        end else begin
            r_prev_blank <= iBLANK_n;
            r_prev_vs    <= iVS;
            // Frame start outranks the end-of-line step
            if (w_vs_fall) begin
                r_x_cnt <= '0;
                r_y_cnt <= '0;
                r_en_s  <= iCUR_EN;
                r_x_s   <= iCUR_X;
                r_y_s   <= iCUR_Y;
            end else if (w_blank_fall) begin
                r_x_cnt <= '0;
                if (r_y_cnt != C_CMAX)
                    r_y_cnt <= r_y_cnt + 1'b1;
            end else if (iBLANK_n && (r_x_cnt != C_CMAX)) begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oBLANK_n <= 1'b0;
            oHS      <= 1'b0;
            oVS      <= 1'b0;
            oR       <= '0;
            oG       <= '0;
            oB       <= '0;
            oFRAME   <= 1'b0;
        end else begin
            oBLANK_n <= iBLANK_n;
            oHS      <= iHS;
            oVS      <= iVS;
            oFRAME   <= w_vs_fall;
            if (w_hit) begin
                oR <= w_cur_r;
                oG <= w_cur_g;
                oB <= w_cur_b;
            end else begin
                oR <= iR;
                oG <= iG;
                oB <= iB;
            end
        end
    end

endmodule
`default_nettype wire
